dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator-side controller that drives the data memory's RE/WE/RA/WA/WD/Data_Size port and consumes its registered RD output.
- Accepts one load/store request at a time from the CPU pipeline over a valid/ready handshake.
- Always accesses memory as full words. Sub-word loads are extracted and sign- or zero-extended locally; sub-word stores are done as a read-modify-write.
- Reports misaligned or out-of-range accesses as errors without touching memory.

Parameters:
- ADDR_W, 12, byte-address width; matches the memory RA/WA width.
- MEM_WORDS, 1024, number of 32-bit words; byte addresses >= 4*MEM_WORDS are out of range.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = word, 1 = half, 2 = byte, 3 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; misaligned, out-of-range or reserved size.
- RE  out  1  memory read enable.
- WE  out  1  memory write enable.
- RA  out  ADDR_W  memory read byte address, word-aligned (low 2 bits = 0).
- WA  out  ADDR_W  memory write byte address, word-aligned.
- WD  out  32  memory write data.
- Data_Size  out  2  constant 0; the memory is always accessed as words.
- RD  in  32  memory read data; valid the cycle after the posedge that sampled RE = 1.

Behaviour:
- Reset, asynchronous while RST_N = 0:
  - State goes to IDLE.
  - RE, WE, resp_valid and resp_err = 0.
  - RA, WA, WD and resp_rdata = 0.
  - req_ready = 1 once RST_N deasserts.
  - Reset mid-operation aborts the request with no response. An in-flight WE drops immediately, so no write is issued after reset.
- All outputs are registered.
- Acceptance:
  - A request is accepted on a posedge where req_valid && req_ready.
  - At acceptance the controller latches we, size, signed, addr and wdata. Request inputs are ignored until the next IDLE.
- Error check at acceptance. The request is an error if any of these hold:
  - size = 3;
  - size = 0 and addr[1:0] != 0;
  - size = 1 and addr[0] = 1;
  - addr >= 4*MEM_WORDS.
  - An error goes directly to DONE with resp_err = 1 and rdata = 0. No RE or WE is issued.
- States:
  - IDLE -> READ: load, or sub-word store.
  - IDLE -> WRITE: word store.
  - IDLE -> DONE: error.
  - READ: RE = 1, RA = {addr[ADDR_W-1:2], 2'b00}; next state WAIT.
  - WAIT: RE = 0; RD is sampled at the end of this cycle.
    - Load: format the data -> DONE.
    - Sub-word store: merge -> WRITE.
  - WRITE: WE = 1, WA = word address, WD = merged or full word; next state DONE.
  - DONE: resp_valid = 1 for exactly one cycle; next state IDLE.
- RE and WE are never high in the same cycle. RE, WE and resp_valid are 0 in every state other than the one that asserts them.
- Lane order is little-endian:
  - byte k = RD[8k+7:8k];
  - half at offset 0 = [15:0], half at offset 2 = [31:16].
- Load format:
  - word: RD unchanged;
  - half/byte: the selected lane, sign-extended if signed = 1, otherwise zero-extended.
- Store merge: replace only the addressed lane of RD with wdata[7:0] or wdata[15:0]. All other bytes are preserved.
- Latency, counted as cycles from the acceptance edge to resp_valid high:
  - word store 2 (WRITE, DONE);
  - load 3 (READ, WAIT, DONE);
  - sub-word store 4 (READ, WAIT, WRITE, DONE);
  - error 1.
- Next acceptance is possible in the cycle after DONE, i.e. req_ready is high in that cycle.

Decomposition:
- Shared package:
  - size encodings (SZ_WORD = 0, SZ_HALF = 1, SZ_BYTE = 2);
  - FSM state enum;
  - MEM_WORDS default.
- One sub-module, dmem_lane_fmt: purely combinational.
  - Load extract and extend: addr[1:0], size, signed, RD -> rdata.
  - Store merge: addr[1:0], size, wdata, RD -> merged word.

Test Plan:
- Word store 0xDEADBEEF to addr 4, then word load from addr 4:
  - one WE pulse with WA = 4, WD = 0xDEADBEEF;
  - load returns 0xDEADBEEF, resp_err = 0;
  - latencies 2 and 3.
- Byte load from addr 7 with word 1 = 0x80FF1234:
  - signed returns 0xFFFFFF80;
  - unsigned returns 0x00000080.
- Half store 0xABCD to addr 6 over 0x11223344:
  - RE at RA = 4, then WE with WD = 0xABCD3344;
  - latency 4.
- Half load at addr 5 and word load at addr 4096:
  - resp_err = 1, rdata = 0, latency 1;
  - RE and WE stay 0.
- RST_N pulsed low while in WRITE: WE drops in the same cycle, memory word is unchanged, no resp_valid, req_ready = 1 after release.
- Back-to-back requests with req_valid held high: req_ready is low during each operation, and each request produces exactly one resp_valid.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// FSM states and the default memory depth.
package dmem_access_ctrl_pkg;

   localparam int unsigned MEM_WORDS_DEF = 1024;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Size 3 is reserved; word needs 4-byte and half needs 2-byte alignment.
   function automatic logic size_addr_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_WORD: bad = (off != 2'b00);
         SZ_HALF: bad = off[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Little-endian lane logic: extracts and extends sub-word load data, and
// merges sub-word store data into a word read back from memory.
module dmem_lane_fmt
   import dmem_access_ctrl_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        sgn_i,
   input  logic [31:0] rd_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];
   end

   always_comb begin
      rdata_o = '0;
      case (size_i)
         SZ_WORD: rdata_o = rd_i;
         SZ_HALF: rdata_o = {{16{sgn_i & half_sel[15]}}, half_sel};
         SZ_BYTE: rdata_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
         default: rdata_o = '0;
      endcase
   end

   // Only the addressed lane is replaced; every other byte of rd_i survives.
   always_comb begin
      merged_o = rd_i;
      case (size_i)
         SZ_WORD: merged_o = wdata_i;
         SZ_HALF: begin
            if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
            else          merged_o[15:0]  = wdata_i[15:0];
         end
         SZ_BYTE: merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         default: merged_o = rd_i;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller in front of a word-wide data memory; sub-word stores
// are read-modify-write, bad requests are answered without a memory access.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   // Handshake: a request transfers on a CLK posedge where req_valid and
   // req_ready are both high; req_ready is high only while the FSM is IDLE.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              RE,
   output logic              WE,
   output logic [ADDR_W-1:0] RA,
   output logic [ADDR_W-1:0] WA,
   output logic [31:0]       WD,
   output logic [1:0]        Data_Size,
   input  logic [31:0]       RD,
   output logic [2:0]        dbg_state
);

   localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

   state_t              state_q;
   logic                ready_q;
   logic                re_q;
   logic                we_q;
   logic [ADDR_W-1:0]   ra_q;
   logic [ADDR_W-1:0]   wa_q;
   logic [31:0]         wd_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [31:0]         rdata_q;

   logic                op_we_q;
   logic [1:0]          op_size_q;
   logic                op_sgn_q;
   logic [ADDR_W-1:0]   op_addr_q;
   logic [31:0]         op_wdata_q;

   logic [31:0]         addr_ext;
   logic                req_err_d;
   logic [ADDR_W-1:0]   req_word_addr;
   logic [ADDR_W-1:0]   op_word_addr;
   logic [31:0]         fmt_rdata;
   logic [31:0]         merged_wd;

   always_comb begin
      addr_ext      = 32'(req_addr);
      req_err_d     = size_addr_bad(req_size, req_addr[1:0]) || (addr_ext >= MEM_BYTES);
      req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
      op_word_addr  = {op_addr_q[ADDR_W-1:2], 2'b00};
   end

   dmem_lane_fmt u_lane_fmt (
      .off_i    (op_addr_q[1:0]),
      .size_i   (op_size_q),
      .sgn_i    (op_sgn_q),
      .rd_i     (RD),
      .wdata_i  (op_wdata_q),
      .rdata_o  (fmt_rdata),
      .merged_o (merged_wd)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b1;
         re_q         <= 1'b0;
         we_q         <= 1'b0;
         ra_q         <= '0;
         wa_q         <= '0;
         wd_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
         op_we_q      <= 1'b0;
         op_size_q    <= SZ_WORD;
         op_sgn_q     <= 1'b0;
         op_addr_q    <= '0;
         op_wdata_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && ready_q) begin
                  ready_q    <= 1'b0;
                  op_we_q    <= req_we;
                  op_size_q  <= req_size;
                  op_sgn_q   <= req_signed;
                  op_addr_q  <= req_addr;
                  op_wdata_q <= req_wdata;
                  if (req_err_d) begin
                     state_q      <= ST_DONE;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     rdata_q      <= '0;
                  end else if (req_we && (req_size == SZ_WORD)) begin
                     state_q <= ST_WRITE;
                     we_q    <= 1'b1;
                     wa_q    <= req_word_addr;
                     wd_q    <= req_wdata;
                  end else begin
                     state_q <= ST_READ;
                     re_q    <= 1'b1;
                     ra_q    <= req_word_addr;
                  end
               end
            end
            ST_READ: begin
               re_q    <= 1'b0;
               state_q <= ST_WAIT;
            end
            // RD carries the word read by the READ-cycle RE at this edge.
            ST_WAIT: begin
               if (op_we_q) begin
                  state_q <= ST_WRITE;
                  we_q    <= 1'b1;
                  wa_q    <= op_word_addr;
                  wd_q    <= merged_wd;
               end else begin
                  state_q      <= ST_DONE;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  rdata_q      <= fmt_rdata;
               end
            end
            ST_WRITE: begin
               we_q         <= 1'b0;
               state_q      <= ST_DONE;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               rdata_q      <= '0;
            end
            ST_DONE: begin
               state_q      <= ST_IDLE;
               ready_q      <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               rdata_q      <= '0;
            end
            default: begin
               state_q      <= ST_IDLE;
               ready_q      <= 1'b1;
               re_q         <= 1'b0;
               we_q         <= 1'b0;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               rdata_q      <= '0;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign RE         = re_q;
   assign WE         = we_q;
   assign RA         = ra_q;
   assign WA         = wa_q;
   assign WD         = wd_q;
   assign Data_Size  = SZ_WORD;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a word-wide memory model that
// returns RD one cycle after RE.
module tb_dmem_access_ctrl;

   localparam int AW = 13;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_signed = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          RE;
   logic          WE;
   logic [AW-1:0] RA;
   logic [AW-1:0] WA;
   logic [31:0]   WD;
   logic [1:0]    Data_Size;
   logic [31:0]   RD = '0;
   logic [2:0]    dbg_state;

   dmem_access_ctrl #(.ADDR_W(AW), .MEM_WORDS(1024)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .RE         (RE),
      .WE         (WE),
      .RA         (RA),
      .WA         (WA),
      .WD         (WD),
      .Data_Size  (Data_Size),
      .RD         (RD),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // memory model
   logic [31:0] mem [0:1023];

   always @(posedge CLK) begin
      if (RE) RD <= mem[RA[11:2]];
      if (WE) mem[WA[11:2]] <= WD;
   end

   // strobe monitor
   int          re_cnt = 0;
   int          we_cnt = 0;
   int          resp_cnt = 0;
   int          overlap_cnt = 0;
   logic [AW-1:0] last_ra = '0;
   logic [AW-1:0] last_wa = '0;
   logic [31:0] last_wd = '0;

   always @(negedge CLK) begin
      if (RE && WE) overlap_cnt++;
      if (RE) begin re_cnt++; last_ra = RA; end
      if (WE) begin we_cnt++; last_wa = WA; last_wd = WD; end
      if (resp_valid) resp_cnt++;
   end

   // scoreboard
   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          we;
      logic [1:0]    size;
      logic          sgn;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      int            exp_lat;
      int            exp_re;
      int            exp_we;
      logic [31:0]   exp_wd;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] er, input logic ee, input int lat,
                               input int re, input int wec, input logic [31:0] ewd);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
      v.exp_re = re; v.exp_we = wec; v.exp_wd = ewd;
      return v;
   endfunction

   // driver: one request, checks latency, response and memory strobes
   task automatic run_req(input vec_t v, input int idx);
      int lat;
      int wait_n;
      int re0;
      int we0;
      logic [31:0] exp;
      logic [AW-1:0] waddr;
      string tag;
      tag = $sformatf("v%0d", idx);
      waddr = {v.addr[AW-1:2], 2'b00};
      @(negedge CLK);
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin @(negedge CLK); wait_n++; end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      exp_q.push_back(v.exp_rdata);
      re0 = re_cnt;
      we0 = we_cnt;
      req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      req_wdata = 32'h5555_5555;
      lat = 1;
      while (!resp_valid && lat < 8) begin @(posedge CLK); #1; lat++; end
      exp = exp_q.pop_front();
      chk({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
      chk({tag, "_rdata"}, resp_rdata, exp);
      chk({tag, "_re_cnt"}, 32'(re_cnt - re0), 32'(v.exp_re));
      chk({tag, "_we_cnt"}, 32'(we_cnt - we0), 32'(v.exp_we));
      if (v.exp_re != 0) chk({tag, "_ra"}, 32'(last_ra), 32'(waddr));
      if (v.exp_we != 0) begin
         chk({tag, "_wa"}, 32'(last_wa), 32'(waddr));
         chk({tag, "_wd"}, last_wd, v.exp_wd);
      end
      @(posedge CLK);
      #1;
      chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
   endtask

   vec_t tbl [21];

   initial begin
      int acc;
      int rsp;
      int rdy;
      int we0;
      int rsp0;

      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[3]    = 32'hCAFE_F00D;
      mem[1023] = 32'h7F00_0000;

      //            we    size  sgn   addr       wdata          rdata          err lat re we wd
      tbl[0]  = mk(1'b1, 2'd0, 1'b0, 13'h004, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 2, 0, 1, 32'hDEADBEEF);
      tbl[1]  = mk(1'b0, 2'd0, 1'b0, 13'h004, 32'h0,        32'hDEADBEEF,  1'b0, 3, 1, 0, 32'h0);
      tbl[2]  = mk(1'b1, 2'd0, 1'b0, 13'h004, 32'h80FF1234, 32'h0000_0000, 1'b0, 2, 0, 1, 32'h80FF1234);
      tbl[3]  = mk(1'b0, 2'd2, 1'b1, 13'h007, 32'h0,        32'hFFFFFF80,  1'b0, 3, 1, 0, 32'h0);
      tbl[4]  = mk(1'b0, 2'd2, 1'b0, 13'h007, 32'h0,        32'h00000080,  1'b0, 3, 1, 0, 32'h0);
      tbl[5]  = mk(1'b0, 2'd2, 1'b1, 13'h005, 32'h0,        32'h00000012,  1'b0, 3, 1, 0, 32'h0);
      tbl[6]  = mk(1'b0, 2'd1, 1'b1, 13'h006, 32'h0,        32'hFFFF80FF,  1'b0, 3, 1, 0, 32'h0);
      tbl[7]  = mk(1'b0, 2'd1, 1'b0, 13'h004, 32'h0,        32'h00001234,  1'b0, 3, 1, 0, 32'h0);
      tbl[8]  = mk(1'b1, 2'd0, 1'b0, 13'h004, 32'h11223344, 32'h0000_0000, 1'b0, 2, 0, 1, 32'h11223344);
      tbl[9]  = mk(1'b1, 2'd1, 1'b0, 13'h006, 32'h9999ABCD, 32'h0000_0000, 1'b0, 4, 1, 1, 32'hABCD3344);
      tbl[10] = mk(1'b0, 2'd0, 1'b0, 13'h004, 32'h0,        32'hABCD3344,  1'b0, 3, 1, 0, 32'h0);
      tbl[11] = mk(1'b1, 2'd2, 1'b0, 13'h005, 32'h0000005A, 32'h0000_0000, 1'b0, 4, 1, 1, 32'hABCD5A44);
      tbl[12] = mk(1'b1, 2'd2, 1'b0, 13'h004, 32'h00FFEE77, 32'h0000_0000, 1'b0, 4, 1, 1, 32'hABCD5A77);
      tbl[13] = mk(1'b0, 2'd1, 1'b1, 13'h006, 32'h0,        32'hFFFFABCD,  1'b0, 3, 1, 0, 32'h0);
      tbl[14] = mk(1'b0, 2'd1, 1'b0, 13'h006, 32'h0,        32'h0000ABCD,  1'b0, 3, 1, 0, 32'h0);
      tbl[15] = mk(1'b0, 2'd1, 1'b0, 13'h005, 32'h0,        32'h0000_0000, 1'b1, 1, 0, 0, 32'h0);
      tbl[16] = mk(1'b0, 2'd0, 1'b0, 13'h1000, 32'h0,       32'h0000_0000, 1'b1, 1, 0, 0, 32'h0);
      tbl[17] = mk(1'b0, 2'd0, 1'b0, 13'h002, 32'h0,        32'h0000_0000, 1'b1, 1, 0, 0, 32'h0);
      tbl[18] = mk(1'b1, 2'd3, 1'b0, 13'h000, 32'h12345678, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0);
      tbl[19] = mk(1'b1, 2'd1, 1'b0, 13'h003, 32'h12345678, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0);
      tbl[20] = mk(1'b0, 2'd2, 1'b0, 13'hFFF, 32'h0,        32'h0000007F,  1'b0, 3, 1, 0, 32'h0);

      // reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_re", 32'(RE), 32'd0);
      chk("rst_we", 32'(WE), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_ra", 32'(RA), 32'd0);
      chk("rst_wa", 32'(WA), 32'd0);
      chk("rst_wd", WD, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("data_size", 32'(Data_Size), 32'd0);

      for (int i = 0; i < 21; i++) run_req(tbl[i], i);
      chk("mem_word1", mem[1], 32'hABCD5A77);
      chk("mem_word0_untouched", mem[0], 32'h0);

      // back-to-back word loads with req_valid held high
      @(negedge CLK);
      acc = 0; rsp = 0; rdy = 0;
      req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 13'h004;
      req_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge CLK);
         if (req_valid && req_ready) acc++;
         if (i < 20 && req_ready) rdy++;
         if (resp_valid) begin
            rsp++;
            chk("b2b_rdata", resp_rdata, 32'hABCD5A77);
         end
         if (i == 19) req_valid = 1'b0;
      end
      chk("b2b_accepts", 32'(acc), 32'd5);
      chk("b2b_resps", 32'(rsp), 32'd5);
      chk("b2b_ready_cycles", 32'(rdy), 32'd5);

      // reset while WE is high
      @(negedge CLK);
      req_we = 1'b1; req_size = 2'd0; req_addr = 13'h00C; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      chk("rstw_we_before", 32'(WE), 32'd1);
      we0 = we_cnt;
      rsp0 = resp_cnt;
      #2;
      RST_N = 1'b0;
      #1;
      chk("rstw_we_dropped", 32'(WE), 32'd0);
      chk("rstw_no_resp", 32'(resp_valid), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      chk("rstw_we_count", 32'(we_cnt - we0), 32'd0);
      chk("rstw_resp_count", 32'(resp_cnt - rsp0), 32'd0);
      chk("rstw_mem_kept", mem[3], 32'hCAFEF00D);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      run_req(mk(1'b0, 2'd0, 1'b0, 13'h00C, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0, 32'h0), 21);

      chk("re_we_overlap", 32'(overlap_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
